// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types for the decode stage.
// Request FSM states, instruction field positions, decoded bundle.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } req_state_t;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int F3_LSB  = 12;
    localparam int F3_MSB  = 14;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int IMM_LSB = 20;
    localparam int IMM_MSB = 31;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [31:0] raw;
    } dec_inst_t;

    function automatic dec_inst_t decode_fields(input logic [31:0] w);
        dec_inst_t d;
        d.opcode = w[OPC_MSB:OPC_LSB];
        d.rd     = w[RD_MSB:RD_LSB];
        d.funct3 = w[F3_MSB:F3_LSB];
        d.rs1    = w[RS1_MSB:RS1_LSB];
        d.rs2    = w[RS2_MSB:RS2_LSB];
        d.imm    = {{20{w[IMM_MSB]}}, w[IMM_MSB:IMM_LSB]};
        d.raw    = w;
        return d;
    endfunction

endpackage

// File: rtl/inst_queue.sv
// inst_queue: circular instruction FIFO with rd/wr pointers and a count.
// Ports: push_i/data_i in, pop_i/data_o out, flush_i, count_o/full_o/empty_o.
module inst_queue
    import cpu_pkg::*;
#(
    parameter int QDEPTH = 2,
    parameter int WIDTH  = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic                        flush_i,
    input  logic                        push_i,
    input  logic [WIDTH-1:0]            data_i,
    input  logic                        pop_i,
    output logic [WIDTH-1:0]            data_o,
    output logic [$clog2(QDEPTH+1)-1:0] count_o,
    output logic                        full_o,
    output logic                        empty_o
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH+1);

    logic [WIDTH-1:0] r_mem [QDEPTH];
    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (int'(r_count) == QDEPTH);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd];

    assign w_push = push_i && !full_o && !flush_i;
    assign w_pop  = pop_i && !empty_o && !flush_i;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr] <= data_i;
        end
    end

    // Power-of-two depth, so pointer wrap is plain overflow.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (flush_i) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wr <= r_wr + PW'(1);
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!reset_ni)
        !(push_i && full_o)
    );

endmodule

// File: rtl/decode_stage.sv
// decode_stage: fetch request FSM, 2-entry queue, decoded output register.
// Ports: fetch_* handshake, flush_i, dec_* valid/ready + fields, q_count_o.
module decode_stage
    import cpu_pkg::*;
#(
    parameter int QDEPTH     = 2,
    parameter int INST_WIDTH = 32
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    input  logic [INST_WIDTH-1:0]       fetch_inst_i,
    input  logic                        fetch_ready_i,
    output logic                        fetch_consume_o,
    input  logic                        flush_i,
    output logic                        dec_valid_o,
    input  logic                        dec_ready_i,
    output logic [6:0]                  dec_opcode_o,
    output logic [4:0]                  dec_rd_o,
    output logic [2:0]                  dec_funct3_o,
    output logic [4:0]                  dec_rs1_o,
    output logic [4:0]                  dec_rs2_o,
    output logic [31:0]                 dec_imm_o,
    output logic [INST_WIDTH-1:0]       dec_raw_o,
    output logic [$clog2(QDEPTH+1)-1:0] q_count_o
);

    localparam int CW = $clog2(QDEPTH+1);

    req_state_t            r_state;
    logic                  r_drop;
    logic                  r_valid;
    logic [INST_WIDTH-1:0] r_raw;

    logic [INST_WIDTH-1:0] w_head;
    logic [CW-1:0]         w_cnt;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_inflight;
    logic                  w_can_req;
    logic                  w_req;
    logic                  w_capture;
    logic                  w_push;
    logic                  w_load;
    dec_inst_t             w_dec;

    assign w_inflight = (r_state != IDLE);
    assign w_can_req  = !w_full &&
                        ((int'(w_cnt) + int'(w_inflight)) < QDEPTH);
    assign w_req      = (r_state == IDLE) && w_can_req && !flush_i;
    assign w_capture  = (r_state == WAIT) && fetch_ready_i;
    assign w_push     = w_capture && !r_drop && !flush_i;
    assign w_load     = (!r_valid || dec_ready_i) && !w_empty && !flush_i;

    // Gated so the pulse is also low while reset is held.
    assign fetch_consume_o = w_req && reset_ni;

    inst_queue #(
        .QDEPTH (QDEPTH),
        .WIDTH  (INST_WIDTH)
    ) u_queue (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .flush_i  (flush_i),
        .push_i   (w_push),
        .data_i   (fetch_inst_i),
        .pop_i    (w_load),
        .data_o   (w_head),
        .count_o  (w_cnt),
        .full_o   (w_full),
        .empty_o  (w_empty)
    );

    // ACK exists because fetch_ready_i may still show the previous word.
    // A flush while a request is outstanding arms r_drop so that the
    // pending word is swallowed on arrival.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state <= IDLE;
            r_drop  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_state <= WAIT;
                    if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                end
                WAIT: begin
                    if (fetch_ready_i) begin
                        r_state <= IDLE;
                        r_drop  <= 1'b0;
                    end else if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_drop  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_valid <= 1'b0;
            r_raw   <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (!r_valid || dec_ready_i) begin
            r_valid <= !w_empty;
            if (w_load) begin
                r_raw <= w_head;
            end
        end
    end

    assign w_dec = decode_fields(r_raw);

    assign dec_valid_o  = r_valid;
    assign dec_opcode_o = w_dec.opcode;
    assign dec_rd_o     = w_dec.rd;
    assign dec_funct3_o = w_dec.funct3;
    assign dec_rs1_o    = w_dec.rs1;
    assign dec_rs2_o    = w_dec.rs2;
    assign dec_imm_o    = w_dec.imm;
    assign dec_raw_o    = r_raw;
    assign q_count_o    = w_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: fetch model + scoreboard bench for decode_stage.
// Expected words queue on issue and are checked on each transfer.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fetch_inst;
    logic        fetch_ready;
    logic        fetch_consume;
    logic        flush;
    logic        dec_valid;
    logic        dec_ready;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] raw;
    logic [1:0]  qcnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] fq[$];
    logic [31:0] exp_q[$];

    bit fl_req, cf_req, ov_en, ov_ready;
    bit m_c, m_pend;
    int m_dly;

    int cyc, cons_n, cons_all, cap_cyc, val_cyc, xfer_n;
    bit cap_seen, val_seen, prev_c;

    decode_stage #(
        .QDEPTH     (2),
        .INST_WIDTH (32)
    ) dut (
        .clk_i           (clk),
        .reset_ni        (rst_n),
        .fetch_inst_i    (fetch_inst),
        .fetch_ready_i   (fetch_ready),
        .fetch_consume_o (fetch_consume),
        .flush_i         (flush),
        .dec_valid_o     (dec_valid),
        .dec_ready_i     (dec_ready),
        .dec_opcode_o    (opc),
        .dec_rd_o        (rd),
        .dec_funct3_o    (f3),
        .dec_rs1_o       (rs1),
        .dec_rs2_o       (rs2),
        .dec_imm_o       (imm),
        .dec_raw_o       (raw),
        .q_count_o       (qcnt)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] sext12(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!dec_valid && n < 200);
        chk({"tmo_", tag}, 32'(dec_valid), 1);
    endtask

    task automatic pulse_ready();
        @(posedge clk);
        #1 dec_ready = 1'b1;
        @(posedge clk);
        #1 dec_ready = 1'b0;
    endtask

    task automatic issue(input logic [31:0] w, input bit expect_out);
        fq.push_back(w);
        if (expect_out) exp_q.push_back(w);
    endtask

    int n, k, x0, vcnt;

    initial begin
        rst_n = 1'b0; dec_ready = 1'b0; fetch_ready = 1'b0;
        fetch_inst = '0; flush = 1'b0;
        fl_req = 0; cf_req = 0; ov_en = 0; ov_ready = 0;
        m_c = 0; m_pend = 0; m_dly = 0;
        cyc = 0; cons_n = 0; cons_all = 0; cap_cyc = 0; val_cyc = 0;
        xfer_n = 0; cap_seen = 0; val_seen = 0; prev_c = 0;

        fork
            forever begin
                @(posedge clk);
                m_c = fetch_consume;
                #1;
                fetch_ready = ov_en ? ov_ready : 1'b0;
                flush = fl_req;
                fl_req = 0;
                if (!rst_n) begin
                    m_pend = 0;
                end else if (m_pend && !ov_en) begin
                    if (m_dly != 0) begin
                        m_dly--;
                    end else if (fq.size() != 0) begin
                        fetch_inst = fq.pop_front();
                        fetch_ready = 1'b1;
                        m_pend = 0;
                        if (cf_req) begin
                            flush = 1'b1;
                            cf_req = 0;
                        end
                    end
                end
                if (m_c) begin
                    m_pend = 1;
                    m_dly = 1;
                end
            end
            forever begin
                logic [31:0] w;
                @(negedge clk);
                cyc++;
                if (rst_n) begin
                    if (fetch_consume) begin
                        chk("consume_pulse", 32'(prev_c), 0);
                        cons_all++;
                        if (!cap_seen) cons_n++;
                    end
                    if (fetch_ready && !cap_seen) begin
                        cap_seen = 1;
                        cap_cyc = cyc;
                    end
                    if (dec_valid && !val_seen) begin
                        val_seen = 1;
                        val_cyc = cyc;
                    end
                    if (flush) begin
                        exp_q.delete();
                    end else if (dec_valid && dec_ready) begin
                        xfer_n++;
                        if (exp_q.size() == 0) begin
                            chk("xfer_unexpected", raw, 32'hFFFF_FFFF);
                        end else begin
                            w = exp_q.pop_front();
                            chk("xfer_raw", raw, w);
                            chk("xfer_fields",
                                32'({rs2, rs1, f3, rd, opc}), 32'(w[24:0]));
                            chk("xfer_imm", imm, sext12(w));
                        end
                    end
                end
                prev_c = fetch_consume && rst_n;
            end
        join_none

        // Reset state
        issue(32'h0050_0093, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(dec_valid), 0);
        chk("rst_consume", 32'(fetch_consume), 0);
        chk("rst_qcnt", 32'(qcnt), 0);
        chk("rst_raw", raw, 0);
        rst_n = 1'b1;

        // First word: addi x1, x0, 5
        wait_valid("first");
        @(posedge clk);
        chk("t1_opcode", 32'(opc), 32'h13);
        chk("t1_rd", 32'(rd), 1);
        chk("t1_rs1", 32'(rs1), 0);
        chk("t1_imm", imm, 5);
        chk("t1_consumes", 32'(cons_n), 1);
        chk("t1_latency", 32'(val_cyc - cap_cyc), 2);

        // Sign-extension boundary
        issue(32'hFFF0_0113, 1);
        pulse_ready();
        wait_valid("sext");
        chk("t2_raw", raw, 32'hFFF0_0113);
        chk("t2_imm", imm, 32'hFFFF_FFFF);
        chk("t2_rd", 32'(rd), 2);
        chk("t2_funct3", 32'(f3), 0);
        pulse_ready();

        // Backpressure: queue fills, consume stops, output holds
        issue(32'h0031_2233, 1);
        issue(32'h8005_A283, 1);
        issue(32'h7FF0_0313, 1);
        issue(32'h00C5_84B3, 1);
        n = 0;
        while (qcnt != 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_qfull", 32'(qcnt), 2);
        repeat (4) @(negedge clk);
        k = cons_all;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("bp_hold_raw", raw, 32'h0031_2233);
            chk("bp_hold_valid", 32'(dec_valid), 1);
        end
        chk("bp_no_consume", 32'(cons_all - k), 0);
        chk("bp_qcnt_hold", 32'(qcnt), 2);
        @(posedge clk);
        #1;
        x0 = xfer_n;
        dec_ready = 1'b1;
        repeat (3) @(posedge clk);
        chk("bp_b2b", 32'(xfer_n - x0), 3);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("bp_drained", 32'(exp_q.size()), 0);
        @(posedge clk);
        #1 dec_ready = 1'b0;

        // Flush while waiting: next word swallowed
        repeat (3) @(posedge clk);
        fl_req = 1;
        repeat (3) @(posedge clk);
        issue(32'hDEAD_BEEF, 0);
        vcnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dec_valid) vcnt++;
        end
        chk("fl_swallow_valid", 32'(vcnt), 0);
        chk("fl_swallow_qcnt", 32'(qcnt), 0);
        issue(32'h0000_0013, 1);
        wait_valid("after_flush");
        chk("fl_next_raw", raw, 32'h0000_0013);
        pulse_ready();

        // Flush coinciding with a capture
        issue(32'h0010_0193, 1);
        issue(32'h0020_0213, 1);
        n = 0;
        while (!(qcnt == 1 && dec_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cf_setup_qcnt", 32'(qcnt), 1);
        cf_req = 1;
        issue(32'h0030_0293, 1);
        n = 0;
        while (fq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("cf_qcnt", 32'(qcnt), 0);
        chk("cf_valid", 32'(dec_valid), 0);
        issue(32'h0040_0313, 1);
        wait_valid("cf_next");
        chk("cf_next_raw", raw, 32'h0040_0313);
        pulse_ready();

        // Asynchronous reset mid-WAIT, then stale ready
        issue(32'h0050_0393, 1);
        wait_valid("pre_rst");
        @(negedge clk);
        ov_ready = 0;
        ov_en = 1;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(dec_valid), 0);
        chk("arst_raw", raw, 0);
        chk("arst_imm", imm, 0);
        chk("arst_qcnt", 32'(qcnt), 0);
        chk("arst_consume", 32'(fetch_consume), 0);
        exp_q.delete();
        ov_ready = 1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        ov_ready = 0;
        repeat (6) @(negedge clk);
        chk("stale_qcnt", 32'(qcnt), 0);
        chk("stale_valid", 32'(dec_valid), 0);
        issue(32'h0060_0413, 1);
        ov_en = 0;
        wait_valid("post_rst");
        chk("post_rst_raw", raw, 32'h0060_0413);
        pulse_ready();
        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
